tcache_req_responder: RTL
=========================

Name: tcache_req_responder

Overview:
- Slave-side endpoint for the texture-cache request interface. Accepts per-lane requests (valid/rw/byteen/addr/data/tag with per-lane ready) and services one request per cycle against a local word-addressed scratch memory.
- Writes commit with byte enables and return no response.
- Reads return data plus tag and lane index through a buffered valid/ready response port.
- Used as the memory-side model and bring-up target behind the texture unit, and as a standalone responder for request-master verification.

Parameters:
- NUM_REQS, 4, number of request lanes
- WORD_SIZE, 4, bytes per word; data width = 8*WORD_SIZE
- ADDR_WIDTH, 32, word-address width
- TAG_WIDTH, 8, request tag width
- MEM_DEPTH, 256, scratch words; power of two
- RSP_DEPTH, 4, response FIFO entries; minimum 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQS  per-lane request valid
- req_rw  in  NUM_REQS  1=write, 0=read
- req_byteen  in  NUM_REQS*WORD_SIZE  per-lane byte enables
- req_addr  in  NUM_REQS*ADDR_WIDTH  per-lane word address
- req_data  in  NUM_REQS*8*WORD_SIZE  per-lane write data
- req_tag  in  NUM_REQS*TAG_WIDTH  per-lane tag
- req_ready  out  NUM_REQS  per-lane accept
- rsp_valid  out  1  read response valid
- rsp_lane  out  max(1,clog2(NUM_REQS))  originating lane
- rsp_data  out  8*WORD_SIZE  read data
- rsp_tag  out  TAG_WIDTH  echoed tag
- rsp_ready  in  1  response consumer ready
- perf_reads  out  32  count of reads accepted, wraps modulo 2^32

Behaviour:
- Reset: asynchronous, active-high. Clears rsp_valid, FIFO pointers/count, in-flight flag, round-robin pointer (to lane 0) and perf_reads. req_ready=0 while reset is asserted. Memory contents are not cleared.
- Handshake: lane i fires when req_valid[i] && req_ready[i]. At most one req_ready bit is high per cycle. req_ready may depend combinationally on req_valid. No combinational path from rsp_ready to req_ready.
- Arbitration: round-robin over valid lanes, searching from the lane after the last granted lane. The pointer advances only on a fire.
- Accept condition: fifo_count + inflight < RSP_DEPTH. Applies to reads and writes alike, so grant order is strict.
- Address: memory index = req_addr[clog2(MEM_DEPTH)-1:0]. Upper bits are ignored (aliasing).
- Write fired in cycle T: bytes with byteen=1 update at the T edge. byteen=0 is a legal no-op. No response.
- Read fired in cycle T: memory data and {lane, tag} are registered at the T edge (inflight=1 in T+1). The entry is pushed into the FIFO at the T+1 edge. rsp_valid is high from cycle T+2. perf_reads increments at the T edge.
- Read-after-write: a read at T+1 to an address written at T returns the new bytes.
- FIFO: in-order. Push and pop in the same cycle leave the count unchanged. When full, req_ready=0 on all lanes. With rsp_ready held low, at most RSP_DEPTH reads are outstanding and none is dropped.
- Response outputs are stable while rsp_valid && !rsp_ready.
- Reset mid-operation: in-flight and queued responses are discarded. rsp_valid drops immediately (asynchronously).
- Throughput: one request per cycle sustained when rsp_ready=1.

Decomposition:
- Package tcache_resp_pkg:
  - typedef rsp_entry_t {lane, tag, data}
  - LANE_BITS localparam helper
  - clog2-based index width helper
- Sub-module tcache_rsp_fifo: parameterised synchronous FIFO of rsp_entry_t with count output, async reset.
- Round-robin grant logic stays inline.

Test Plan:
- Write lane0 addr 0x10, data 0xDEADBEEF, byteen 0xF; then read lane2 addr 0x10, tag 0x5A -> rsp_valid 2 cycles after read fire; rsp_data=0xDEADBEEF, rsp_tag=0x5A, rsp_lane=2; perf_reads=1.
- Partial write byteen 0x3, data 0x00001234 over 0xDEADBEEF at 0x10; then read -> 0xDEAD1234. byteen 0x0 write -> data unchanged.
- All 4 lanes valid reads, tags 0..3, rsp_ready=1 -> grants 0,1,2,3 in consecutive cycles; responses in that order, one per cycle.
- rsp_ready=0 with continuous reads -> exactly RSP_DEPTH (4) accepted, then req_ready=0. Raising rsp_ready drains 4 responses in order and acceptance resumes.
- Addr 0x110 with MEM_DEPTH=256 -> aliases 0x10: write 0x0110, then read 0x0010 returns the written data.
- Reset asserted while 2 responses are queued -> rsp_valid=0 immediately, perf_reads=0, no stale response after release. Memory data written before reset is still readable.

Source files
------------

// File: rtl/tcache_resp_pkg.sv
// Shared types and sizing helpers for the texture-cache request responder.
package tcache_resp_pkg;

    localparam int unsigned NUM_REQS_DEF  = 4;
    localparam int unsigned WORD_SIZE_DEF = 4;
    localparam int unsigned TAG_WIDTH_DEF = 8;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned LANE_BITS  = idx_bits(NUM_REQS_DEF);
    localparam int unsigned DATA_WIDTH = 8 * WORD_SIZE_DEF;

    typedef struct packed {
        logic [LANE_BITS-1:0]     lane;
        logic [TAG_WIDTH_DEF-1:0] tag;
        logic [DATA_WIDTH-1:0]    data;
    } rsp_entry_t;

endpackage

// File: rtl/tcache_rsp_fifo.sv
// In-order response queue of rsp_entry_t with occupancy count and registered valid.
module tcache_rsp_fifo
    import tcache_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  rsp_entry_t       push_data,
    input  logic             pop,
    output rsp_entry_t       head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = idx_bits(DEPTH);

    rsp_entry_t       store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    // Wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop     = pop && valid;
        do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    assign head = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
            valid <= (count_next != '0);
        end
    end

endmodule

// File: rtl/tcache_req_responder.sv
// Texture-cache request endpoint: round-robin lane arbiter in front of a byte-enabled
// scratch memory, returning reads through a buffered valid/ready response port.
module tcache_req_responder
    import tcache_resp_pkg::*;
#(
    parameter int unsigned NUM_REQS   = NUM_REQS_DEF,
    parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = TAG_WIDTH_DEF,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS-1:0]               req_rw,
    input  logic [NUM_REQS*WORD_SIZE-1:0]     req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQS*8*WORD_SIZE-1:0]   req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
    output logic [NUM_REQS-1:0]               req_ready,
    output logic                              rsp_valid,
    output logic [idx_bits(NUM_REQS)-1:0]     rsp_lane,
    output logic [8*WORD_SIZE-1:0]            rsp_data,
    output logic [TAG_WIDTH-1:0]              rsp_tag,
    input  logic                              rsp_ready,
    output logic [31:0]                       perf_reads
);

    localparam int unsigned DW = 8 * WORD_SIZE;
    localparam int unsigned LW = idx_bits(NUM_REQS);
    localparam int unsigned MW = idx_bits(MEM_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    logic [DW-1:0]        mem [MEM_DEPTH];
    logic [LW-1:0]        rr_ptr;
    logic                 inflight;
    rsp_entry_t           inflight_entry;
    rsp_entry_t           head;
    logic [CW-1:0]        fifo_count;
    logic                 can_accept;
    logic                 grant_found;
    logic [LW-1:0]        grant_lane;
    logic                 fire;
    logic                 fire_rw;
    logic [MW-1:0]        fire_addr;
    logic [WORD_SIZE-1:0] fire_be;
    logic [DW-1:0]        fire_wdata;
    logic [TAG_WIDTH-1:0] fire_tag;
    logic                 unused_addr_bits;

    // Upper address bits alias onto the scratch memory.
    assign unused_addr_bits = ^req_addr;

    // Round-robin: first valid lane at or after rr_ptr.
    always_comb begin
        int unsigned idx;
        logic [LW-1:0] cand;
        grant_found = 1'b0;
        grant_lane  = '0;
        idx         = 0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            idx  = (32'(rr_ptr) + k) % NUM_REQS;
            cand = LW'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_lane  = cand;
            end
        end
    end

    // Outstanding reads include the one waiting in the capture register.
    assign can_accept = ((CW + 1)'(fifo_count) + (CW + 1)'(inflight)) < (CW + 1)'(RSP_DEPTH);
    assign fire       = grant_found && can_accept && !reset;

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[grant_lane] = 1'b1;
        end
    end

    assign fire_rw    = req_rw[grant_lane];
    assign fire_addr  = req_addr[32'(grant_lane) * ADDR_WIDTH +: MW];
    assign fire_be    = req_byteen[32'(grant_lane) * WORD_SIZE +: WORD_SIZE];
    assign fire_wdata = req_data[32'(grant_lane) * DW +: DW];
    assign fire_tag   = req_tag[32'(grant_lane) * TAG_WIDTH +: TAG_WIDTH];

    always_ff @(posedge clk) begin
        if (fire && fire_rw) begin
            for (int unsigned b = 0; b < WORD_SIZE; b++) begin
                if (fire_be[b]) begin
                    mem[fire_addr][8*b +: 8] <= fire_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr         <= '0;
            inflight       <= 1'b0;
            inflight_entry <= '0;
            perf_reads     <= '0;
        end else begin
            inflight <= fire && !fire_rw;
            if (fire) begin
                rr_ptr <= (32'(grant_lane) == NUM_REQS - 1) ? '0 : grant_lane + LW'(1);
            end
            if (fire && !fire_rw) begin
                inflight_entry.lane <= LANE_BITS'(grant_lane);
                inflight_entry.tag  <= TAG_WIDTH_DEF'(fire_tag);
                inflight_entry.data <= DATA_WIDTH'(mem[fire_addr]);
                perf_reads          <= perf_reads + 32'd1;
            end
        end
    end

    tcache_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (inflight_entry),
        .pop       (rsp_ready),
        .head      (head),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

    assign rsp_lane = LW'(head.lane);
    assign rsp_tag  = TAG_WIDTH'(head.tag);
    assign rsp_data = DW'(head.data);

endmodule
